// File: rtl/button_debouncer_pkg.sv
// Shared constants and width helper for the push-button input stage and
// other board pin conditioners.
package button_debouncer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 500000;
    localparam int unsigned HOLD_CYCLES_DEF       = 16;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Conditions a bouncy asynchronous push-button into a debounced level plus
// registered press / release / long-press strobes.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int unsigned CW = clog2(DEBOUNCE_CYCLES) + 1;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic          btn_in_q;
    logic          btn_sync;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // Polarity-corrected input is registered ahead of the synchronizer so
    // a level change is accepted DEBOUNCE_CYCLES+2 edges after the pin moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_in_q <= 1'b0;
        end else begin
            btn_in_q <= btn_raw ^ BTN_ACTIVE_LOW;
        end
    end

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in_q),
        .q_o (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Any sample agreeing with the current level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (btn_sync != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = btn_sync;
                press_d = btn_sync;
                rel_d   = ~btn_sync;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int unsigned HW = clog2(HOLD_CYCLES + 1);

        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic          hold_q, hold_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
            end
        end

        // Saturating count gives exactly one strobe per press.
        always_comb begin
            hold_cnt_d = '0;
            hold_d     = 1'b0;
            if (level_q) begin
                hold_cnt_d = hold_cnt_q;
                if (hold_cnt_q != HW'(HOLD_CYCLES)) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
                hold_d = (hold_cnt_q == HW'(HOLD_CYCLES - 1));
            end
        end

        assign hold_pulse = hold_q;
    end else begin : g_no_hold
        assign hold_pulse = 1'b0;
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench: default instance plus an active-low,
// hold-disabled instance.
module tb_button_debouncer;

    logic clk;
    logic rst;
    logic btn_raw;
    logic btn_raw_al;
    logic lvl, pp, rp, hp;
    logic lvl_al, pp_al, rp_al, hp_al;

    int n_cmp;
    int n_err;

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .BTN_ACTIVE_LOW  (1'b0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (lvl),
        .press_pulse   (pp),
        .release_pulse (rp),
        .hold_pulse    (hp)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (0),
        .BTN_ACTIVE_LOW  (1'b1)
    ) u_dut_al (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw_al),
        .btn_level     (lvl_al),
        .press_pulse   (pp_al),
        .release_pulse (rp_al),
        .hold_pulse    (hp_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic e_lvl, input logic e_pp,
                              input logic e_rp, input logic e_hp);
        check({tag, ".level"},   lvl, e_lvl);
        check({tag, ".press"},   pp,  e_pp);
        check({tag, ".release"}, rp,  e_rp);
        check({tag, ".hold"},    hp,  e_hp);
    endtask

    task automatic check_al(input string tag, input logic e_lvl, input logic e_pp,
                            input logic e_rp, input logic e_hp);
        check({tag, ".al_level"},   lvl_al, e_lvl);
        check({tag, ".al_press"},   pp_al,  e_pp);
        check({tag, ".al_release"}, rp_al,  e_rp);
        check({tag, ".al_hold"},    hp_al,  e_hp);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        btn_raw    = 1'b0;
        btn_raw_al = 1'b1;

        // 1: reset and idle
        step(3);
        check_main("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_al("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_main("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 2: clean press, level after edge 6, hold after edge 22
        btn_raw = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            step(1);
            check_main($sformatf("press_e%0d", e), e >= 6, e == 6, 1'b0, e == 22);
        end
        btn_raw = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            step(1);
            check_main($sformatf("rel_e%0d", e), e < 6, 1'b0, e == 6, 1'b0);
        end

        // 3: bounce 1,0,1,0 then hold 1
        btn_raw = 1'b1; step(1);
        check_main("bounce0", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0; step(1);
        check_main("bounce1", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1; step(1);
        check_main("bounce2", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0; step(1);
        check_main("bounce3", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            step(1);
            check_main($sformatf("bounce_e%0d", e), e >= 6, e == 6, 1'b0, e == 22);
        end

        // 4: 3-cycle drop is rejected, long drop releases
        btn_raw = 1'b0;
        step(3);
        btn_raw = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step(1);
            check_main($sformatf("short_drop_e%0d", e), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            step(1);
            check_main($sformatf("long_drop_e%0d", e), e < 6, 1'b0, e == 6, 1'b0);
        end

        // 5: active-low input, hold detection disabled
        btn_raw_al = 1'b0;
        for (int e = 0; e <= 205; e++) begin
            step(1);
            check_al($sformatf("al_e%0d", e), e >= 6, e == 6, 1'b0, 1'b0);
        end
        btn_raw_al = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            step(1);
            check_al($sformatf("al_rel_e%0d", e), e < 6, 1'b0, e == 6, 1'b0);
        end

        // 6: reset at edge 4 of a press, fresh latency after reset drops
        btn_raw = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step(1);
            check_main($sformatf("pre_rst_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        step(2);
        check_main("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            step(1);
            check_main($sformatf("post_rst_e%0d", e), e >= 6, e == 6, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream input stage for the light toggle logic. Conditions a raw, bouncy, asynchronous push-button into a clean debounced level plus one-cycle event pulses.
- press_pulse drives the toggle enable of the light stage, so one physical press produces exactly one toggle.
- Adds release and long-press (hold) events for future mode control.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change. Must be >=1; elaboration-time error otherwise. Board build uses 500000.
- HOLD_CYCLES, 16, cycles btn_level must stay 1 before hold_pulse fires. 0 disables hold detection.
- BTN_ACTIVE_LOW, 0, 1 = raw input is inverted before synchronization.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw asynchronous button pin.
- btn_level  output  1  debounced level (1 = pressed).
- press_pulse  output  1  one-cycle strobe on debounced 0->1.
- release_pulse  output  1  one-cycle strobe on debounced 1->0.
- hold_pulse  output  1  one-cycle strobe, once per press, after HOLD_CYCLES held.

Behaviour:
- Reset: when rst=1 at a clk edge, clear sync flops, debounce counter, hold counter, btn_level, press_pulse, release_pulse and hold_pulse to 0. Reset dominates all other events in that cycle.
- Input conditioning: compute btn_in = btn_raw XOR BTN_ACTIVE_LOW, then pass it through a 2-flop synchronizer to produce btn_sync. Synchronizer latency is 2 edges.
- Debounce counter (width clog2(DEBOUNCE_CYCLES)+1), evaluated each edge:
  - btn_sync == btn_level: cnt <= 0.
  - btn_sync != btn_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - btn_sync != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= btn_sync, cnt <= 0.
- Latency: with btn_in stable from before edge 0, btn_level changes after edge DEBOUNCE_CYCLES+2. For the default, that is after edge 6.
- Glitch rejection: any return of btn_sync to btn_level before acceptance clears cnt. A run of DEBOUNCE_CYCLES-1 or fewer differing samples never changes btn_level.
- Pulses are registered and asserted at the same edge btn_level changes. Each is high for exactly one cycle:
  - press_pulse on a 0->1 change.
  - release_pulse on a 1->0 change.
  - Never both in the same cycle.
- Hold counter (width clog2(HOLD_CYCLES+1)):
  - btn_level==0: clear to 0.
  - btn_level==1: increment, saturating at HOLD_CYCLES.
  - hold_pulse is set at the edge where the counter goes HOLD_CYCLES-1 -> HOLD_CYCLES. With btn_level rising after edge E, hold_pulse is high after edge E+HOLD_CYCLES for one cycle.
  - Saturation guarantees a single hold_pulse per press.
- Release before hold: the counter clears and no hold_pulse is produced.
- Release in the same cycle the hold counter would have saturated: btn_level is already 0, so no hold_pulse.
- HOLD_CYCLES=0: hold_pulse stays constant 0.
- Reset mid-operation: an in-progress debounce or hold count is discarded. If the button is still held after rst drops, a fresh full latency applies and a new press_pulse is generated.
- Outputs contain no combinational path from btn_raw.

Decomposition:
- Shared package/include: default constants (DEBOUNCE_CYCLES_SIM=4, DEBOUNCE_CYCLES_BOARD=500000, HOLD_CYCLES default) and the clog2 width helper function.
- One sub-module: sync_2ff (1-bit 2-flop synchronizer, clk and synchronous rst). It will be reused for the other pin inputs.

Test Plan:
1. Reset/idle: rst high 3 cycles, btn_raw=0, release -> all outputs 0; no pulses over 50 cycles.
2. Clean press (DEBOUNCE=4, HOLD=16): btn_raw 0->1 before edge 0, held -> btn_level=1 and press_pulse=1 after edge 6 only. press_pulse=0 after edge 7. hold_pulse=1 after edge 22 only.
3. Bounce: btn_raw toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during bouncing. A single press_pulse arrives 6 edges after the last transition; btn_level never glitches.
4. Short release: with btn_level=1, drop btn_raw for 3 cycles -> no release_pulse. A drop held for >=4 synchronized samples -> one release_pulse and btn_level=0.
5. Active-low and hold disable (BTN_ACTIVE_LOW=1, HOLD_CYCLES=0): btn_raw 1->0 -> press_pulse after edge 6; 200-cycle hold -> hold_pulse never asserts.
6. Reset mid-count: assert rst at edge 4 of a press while btn_raw stays 1 -> no press_pulse before reset. After rst drops at edge k, press_pulse occurs after edge k+6.
